// File: rtl/pc_fetch_ctrl_if.sv
// Fetch/decode/redirect signal bundle for pc_fetch_ctrl.
// master = fetch sequencer, slave = memory/decode/next-PC environment.
interface pc_fetch_ctrl_if #(
    parameter int unsigned PC_WIDTH    = 64,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   ena;
    logic                   if_req_o;
    logic [PC_WIDTH-1:0]    if_addr_o;
    logic                   if_gnt_i;
    logic                   if_rvalid_i;
    logic [INSTR_WIDTH-1:0] if_rdata_i;
    logic                   id_valid_o;
    logic                   id_ready_i;
    logic [PC_WIDTH-1:0]    id_pc_o;
    logic [INSTR_WIDTH-1:0] id_instr_o;
    logic                   redirect_i;
    logic [PC_WIDTH-1:0]    redirect_pc_i;
    logic                   ebreak_i;
    logic                   halt_o;
    logic                   misalign_o;

    modport master (
        input  ena,
        output if_req_o, if_addr_o,
        input  if_gnt_i, if_rvalid_i, if_rdata_i,
        output id_valid_o,
        input  id_ready_i,
        output id_pc_o, id_instr_o,
        input  redirect_i, redirect_pc_i, ebreak_i,
        output halt_o, misalign_o
    );

    modport slave (
        output ena,
        input  if_req_o, if_addr_o,
        output if_gnt_i, if_rvalid_i, if_rdata_i,
        input  id_valid_o,
        output id_ready_i,
        input  id_pc_o, id_instr_o,
        output redirect_i, redirect_pc_i, ebreak_i,
        input  halt_o, misalign_o
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one outstanding fetch, presents to decode.
// Optional macro PC_ALIGN_CHECK_EN: trap misaligned redirects to RESET_PC.
module pc_fetch_ctrl #(
    parameter int unsigned         PC_WIDTH    = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(64'h8000_0000),
    parameter int unsigned         INSTR_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic                   kill;
    logic                   halt_pending;
    logic [PC_WIDTH-1:0]    id_pc_q;
    logic [INSTR_WIDTH-1:0] id_instr_q;
    logic                   misalign_q;

    logic [PC_WIDTH-1:0]    redirect_target;
    logic                   redirect_bad;
    logic                   redirect_take;

`ifdef PC_ALIGN_CHECK_EN
    always_comb begin
        redirect_bad    = (bus.redirect_pc_i[1:0] != 2'b00);
        redirect_target = redirect_bad ? RESET_PC : bus.redirect_pc_i;
    end
`else
    always_comb begin
        redirect_bad    = 1'b0;
        redirect_target = {bus.redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    end
`endif

    // ebreak outranks redirect; nothing is redirected once halted
    assign redirect_take = bus.redirect_i && !bus.ebreak_i && (state != S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            kill         <= 1'b0;
            halt_pending <= 1'b0;
            id_pc_q      <= RESET_PC;
            id_instr_q   <= '0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= redirect_take && redirect_bad;
            if (redirect_take) begin
                pc <= redirect_target;
            end
            case (state)
                S_IDLE: begin
                    if (bus.ebreak_i) begin
                        state <= S_HALT;
                    end else if (bus.ena) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.if_gnt_i) begin
                        state <= S_WAIT;
                        if (bus.ebreak_i) begin
                            kill         <= 1'b1;
                            halt_pending <= 1'b1;
                        end else if (bus.redirect_i) begin
                            kill <= 1'b1;
                        end
                    end else if (bus.ebreak_i) begin
                        state <= S_HALT;
                    end
                end
                S_WAIT: begin
                    // A response arriving with a same-cycle redirect/ebreak is stale:
                    // drop it directly since no further rvalid will follow.
                    if (bus.if_rvalid_i) begin
                        kill <= 1'b0;
                        if (bus.ebreak_i || halt_pending) begin
                            state <= S_HALT;
                        end else if (kill || bus.redirect_i) begin
                            state <= bus.ena ? S_REQ : S_IDLE;
                        end else begin
                            id_instr_q <= bus.if_rdata_i;
                            id_pc_q    <= pc;
                            state      <= S_HOLD;
                        end
                    end else if (bus.ebreak_i) begin
                        kill         <= 1'b1;
                        halt_pending <= 1'b1;
                    end else if (bus.redirect_i) begin
                        kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (bus.ebreak_i) begin
                        state <= S_HALT;
                    end else if (bus.redirect_i) begin
                        state <= bus.ena ? S_REQ : S_IDLE;
                    end else if (bus.id_ready_i) begin
                        pc    <= pc + PC_WIDTH'(4);
                        state <= bus.ena ? S_REQ : S_IDLE;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_req_o   = (state == S_REQ);
    assign bus.if_addr_o  = pc;
    assign bus.id_valid_o = (state == S_HOLD);
    assign bus.id_pc_o    = id_pc_q;
    assign bus.id_instr_o = id_instr_q;
    assign bus.halt_o     = (state == S_HALT);
    assign bus.misalign_o = misalign_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a memory responder and accept scoreboard.
module tb_pc_fetch_ctrl;
    localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [63:0] MIS_TARGET = RST_PC;
    localparam logic [63:0] MIS_PULSE  = 64'd1;
`else
    localparam logic [63:0] MIS_TARGET = 64'h8000_00a0;
    localparam logic [63:0] MIS_PULSE  = 64'd0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    exp_t sb[$];

    int unsigned mem_delay;
    logic        data_mode;
    logic        pending;
    logic        gnt_given;
    int unsigned cnt;
    logic [63:0] paddr;
    logic [63:0] gaddr;

    pc_fetch_ctrl_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) bus ();

    pc_fetch_ctrl #(
        .PC_WIDTH(64),
        .RESET_PC(RST_PC),
        .INSTR_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a, input logic mode);
        return mode ? (a[31:0] ^ 32'h5A00_0013) : 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic mode);
        exp_t e;
        e.pc    = a;
        e.instr = mem_word(a, mode);
        sb.push_back(e);
    endtask

    // memory: grants any request at once, answers mem_delay cycles later
    always @(negedge clk) begin
        bus.if_rvalid_i = 1'b0;
        if (rst) begin
            pending        = 1'b0;
            gnt_given      = 1'b0;
            bus.if_gnt_i   = 1'b0;
            bus.if_rdata_i = '0;
        end else begin
            if (gnt_given) begin
                pending = 1'b1;
                cnt     = mem_delay;
                paddr   = gaddr;
            end
            if (pending) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    bus.if_rvalid_i = 1'b1;
                    bus.if_rdata_i  = mem_word(paddr, data_mode);
                    pending         = 1'b0;
                end
            end
            bus.if_gnt_i = bus.if_req_o && !pending;
            gnt_given    = bus.if_gnt_i;
            gaddr        = bus.if_addr_o;
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.id_valid_o && bus.id_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_accept", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("accept_pc", bus.id_pc_o, e.pc);
                check("accept_instr", 64'(bus.id_instr_o), 64'(e.instr));
            end
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        mem_delay = 1;
        data_mode = 1'b0;
        rst = 1'b1;
        bus.ena = 1'b0;
        bus.id_ready_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_pc_i = '0;
        bus.ebreak_i = 1'b0;
        repeat (2) step();

        check("rst_req", 64'(bus.if_req_o), 64'd0);
        check("rst_addr", bus.if_addr_o, RST_PC);
        check("rst_valid", 64'(bus.id_valid_o), 64'd0);
        check("rst_id_pc", bus.id_pc_o, RST_PC);
        check("rst_instr", 64'(bus.id_instr_o), 64'd0);
        check("rst_halt", 64'(bus.halt_o), 64'd0);
        check("rst_mis", 64'(bus.misalign_o), 64'd0);

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("parked_req", 64'(bus.if_req_o), 64'd0);
        end

        // zero-wait streaming, three cycles per instruction
        bus.ena = 1'b1;
        bus.id_ready_i = 1'b1;
        push(64'h8000_0000, 1'b0);
        push(64'h8000_0004, 1'b0);
        step();
        check("s0_req", 64'(bus.if_req_o), 64'd1);
        check("s0_addr", bus.if_addr_o, 64'h8000_0000);
        step(); step();
        check("s0_valid", 64'(bus.id_valid_o), 64'd1);
        check("s0_id_pc", bus.id_pc_o, 64'h8000_0000);
        check("s0_instr", 64'(bus.id_instr_o), 64'h13);
        step();
        check("s1_addr", bus.if_addr_o, 64'h8000_0004);
        step(); step();
        check("s1_id_pc", bus.id_pc_o, 64'h8000_0004);
        data_mode = 1'b1;
        step();
        check("s2_addr", bus.if_addr_o, 64'h8000_0008);

        // decode stall
        bus.id_ready_i = 1'b0;
        push(64'h8000_0008, 1'b1);
        step(); step();
        check("h_valid", 64'(bus.id_valid_o), 64'd1);
        check("h_id_pc", bus.id_pc_o, 64'h8000_0008);
        check("h_instr", 64'(bus.id_instr_o), 64'(mem_word(64'h8000_0008, 1'b1)));
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 64'(bus.id_valid_o), 64'd1);
            check("stall_id_pc", bus.id_pc_o, 64'h8000_0008);
            check("stall_instr", 64'(bus.id_instr_o), 64'(mem_word(64'h8000_0008, 1'b1)));
            check("stall_req", 64'(bus.if_req_o), 64'd0);
            check("stall_pc", bus.if_addr_o, 64'h8000_0008);
        end
        bus.id_ready_i = 1'b1;
        step();
        check("acc_req", 64'(bus.if_req_o), 64'd1);
        check("acc_addr", bus.if_addr_o, 64'h8000_000c);

        // redirect while a slow response is outstanding
        mem_delay = 3;
        step();
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 64'h8000_00a0;
        step();
        bus.redirect_i = 1'b0;
        check("rw_valid1", 64'(bus.id_valid_o), 64'd0);
        check("rw_req1", 64'(bus.if_req_o), 64'd0);
        step();
        check("rw_valid2", 64'(bus.id_valid_o), 64'd0);
        step();
        check("rw_valid3", 64'(bus.id_valid_o), 64'd0);
        check("rw_req", 64'(bus.if_req_o), 64'd1);
        check("rw_addr", bus.if_addr_o, 64'h8000_00a0);
        mem_delay = 1;
        push(64'h8000_00a0, 1'b1);
        step(); step();
        check("rw_hold_pc", bus.id_pc_o, 64'h8000_00a0);
        step();
        check("rw_next", bus.if_addr_o, 64'h8000_00a4);

        // misaligned redirect in REQ with same-cycle grant
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 64'h8000_00a2;
        step();
        bus.redirect_i = 1'b0;
        check("mis_pulse", 64'(bus.misalign_o), MIS_PULSE);
        check("mis_valid", 64'(bus.id_valid_o), 64'd0);
        step();
        check("mis_pulse_end", 64'(bus.misalign_o), 64'd0);
        check("mis_valid2", 64'(bus.id_valid_o), 64'd0);
        check("mis_req", 64'(bus.if_req_o), 64'd1);
        check("mis_addr", bus.if_addr_o, MIS_TARGET);
        push(MIS_TARGET, 1'b1);
        step(); step();
        check("mis_hold_pc", bus.id_pc_o, MIS_TARGET);
        step();
        bus.id_ready_i = 1'b0;
        step(); step();
        check("eb_hold", 64'(bus.id_valid_o), 64'd1);
        check("eb_hold_pc", bus.id_pc_o, MIS_TARGET + 64'd4);

        // ebreak while holding an instruction
        bus.ebreak_i = 1'b1;
        step();
        bus.ebreak_i = 1'b0;
        bus.id_ready_i = 1'b1;
        check("eb_halt", 64'(bus.halt_o), 64'd1);
        check("eb_valid", 64'(bus.id_valid_o), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_req", 64'(bus.if_req_o), 64'd0);
            check("halt_hold", 64'(bus.halt_o), 64'd1);
        end
        bus.redirect_i = 1'b1;
        bus.redirect_pc_i = 64'h1234;
        step();
        bus.redirect_i = 1'b0;
        step();
        check("halt_redir_pc", bus.if_addr_o, MIS_TARGET + 64'd4);
        check("halt_redir_req", 64'(bus.if_req_o), 64'd0);
        check("halt_redir_halt", 64'(bus.halt_o), 64'd1);

        // asynchronous reset out of HALT
        rst = 1'b1;
        #1;
        check("arst_halt", 64'(bus.halt_o), 64'd0);
        check("arst_addr", bus.if_addr_o, RST_PC);
        step();
        rst = 1'b0;
        mem_delay = 3;

        // ebreak while waiting; response three cycles later
        step();
        check("ew_req", 64'(bus.if_req_o), 64'd1);
        step();
        bus.ebreak_i = 1'b1;
        step();
        bus.ebreak_i = 1'b0;
        check("ew_halt0", 64'(bus.halt_o), 64'd0);
        check("ew_valid0", 64'(bus.id_valid_o), 64'd0);
        step();
        check("ew_halt1", 64'(bus.halt_o), 64'd0);
        check("ew_valid1", 64'(bus.id_valid_o), 64'd0);
        step();
        check("ew_halt2", 64'(bus.halt_o), 64'd1);
        check("ew_valid2", 64'(bus.id_valid_o), 64'd0);
        check("ew_req2", 64'(bus.if_req_o), 64'd0);
        repeat (3) step();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch sequencer that owns the architectural PC register and drives instruction-memory requests.
- Hands fetched instructions to decode over a valid/ready handshake.
- Applies redirects from the next-PC select logic (branch/jal/jalr targets) and halts the core on ebreak.
- Sits between the PC mux and IF/ID; at most one fetch outstanding.

Parameters:
- PC_WIDTH, 64, width of PC and address buses
- RESET_PC, 64'h8000_0000, PC value loaded on reset
- INSTR_WIDTH, 32, fetched instruction width

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ena  in  1  core run enable; 0 parks fetch after the current transaction
- if_req_o  out  1  fetch request valid
- if_addr_o  out  PC_WIDTH  fetch address (= pc)
- if_gnt_i  in  1  memory accepts request this cycle
- if_rvalid_i  in  1  fetch response valid (1 cycle pulse, ≥1 cycle after gnt)
- if_rdata_i  in  INSTR_WIDTH  fetched instruction
- id_valid_o  out  1  instruction available to decode
- id_ready_i  in  1  decode accepts instruction
- id_pc_o  out  PC_WIDTH  PC of presented instruction
- id_instr_o  out  INSTR_WIDTH  presented instruction
- redirect_i  in  1  take new PC (branch taken / jump)
- redirect_pc_i  in  PC_WIDTH  redirect target
- ebreak_i  in  1  ebreak retired; stop fetching
- halt_o  out  1  core halted
- misalign_o  out  1  one-cycle pulse: misaligned redirect target trapped

Behaviour:
- Reset (async, rst=1): pc=RESET_PC; state=IDLE; kill=0; halt_pending=0; all outputs 0 except if_addr_o/id_pc_o=RESET_PC and id_instr_o=0.
- States:
  - IDLE: no request. ena=1 → REQ next cycle.
  - REQ: if_req_o=1, if_addr_o=pc. gnt → WAIT.
  - WAIT: awaiting rvalid. rvalid with kill=0 → latch rdata into id_instr_o and pc into id_pc_o; go HOLD. rvalid with kill=1 → discard, clear kill; go REQ (IDLE if ena=0; HALT if halt_pending).
  - HOLD: id_valid_o=1. id_ready_i=1 → pc<=pc+4; go REQ (IDLE if ena=0).
  - HALT: halt_o=1; no requests; id_valid_o=0. Exit only via rst.
- Latency: REQ with gnt at cycle N, rvalid at N+k → id_valid_o=1 at N+k+1. Back-to-back accept gives 3 cycles per instruction with zero-wait memory.
- PC arithmetic: pc+4 and redirect wrap modulo 2^PC_WIDTH, with no overflow flag.
- redirect_i (per state):
  - pc<=redirect_pc_i; id_valid_o drops next cycle; the held instruction is discarded, even if id_ready_i is high in the same cycle.
  - IDLE/HOLD: → REQ (IDLE if ena=0).
  - REQ without gnt: stay REQ, new address next cycle.
  - REQ with gnt same cycle: → WAIT with kill=1.
  - WAIT: kill=1; stay WAIT.
- ebreak_i (priority over redirect_i, also sampled in the same cycle):
  - No response outstanding (IDLE/REQ without gnt/HOLD): → HALT next cycle.
  - WAIT, or REQ with gnt: kill=1, halt_pending=1; → HALT after the rvalid is absorbed.
- ena=0 never aborts an accepted request or a presented instruction. It only blocks entry into REQ.
- rvalid outside WAIT is ignored.
- Reset mid-transaction: state and kill cleared immediately; a late rvalid after reset is ignored (state≠WAIT).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN
- Defined: a redirect with redirect_pc_i[1:0]≠0 does not load the target.
  - pc<=RESET_PC (trap vector); misalign_o pulses 1 cycle; otherwise handled as a normal redirect (kill rules apply).
- Undefined: pc<=redirect_pc_i with bits [1:0] forced to 0; misalign_o tied 0.

Test Plan:
- Reset, ena=1, zero-wait memory returning 0x00000013, id_ready_i=1 → if_addr_o sequence 0x80000000, 0x80000004, 0x80000008; id_pc_o matches; one instruction per 3 cycles.
- id_ready_i=0 for 5 cycles in HOLD → id_valid_o, id_pc_o, id_instr_o stable; no if_req_o; pc advances by 4 only on the accepting cycle.
- redirect_i with redirect_pc_i=0x800000a0 while in WAIT → pending rvalid discarded (id_valid_o stays 0); next if_addr_o=0x800000a0.
- ebreak_i in HOLD → halt_o=1 next cycle; if_req_o=0 for ≥20 cycles; redirect_i then ignored.
- ebreak_i in WAIT with rvalid 3 cycles later → no id_valid_o; halt_o=1 the cycle after rvalid.
- Misaligned redirect to 0x800000a2:
  - with PC_ALIGN_CHECK_EN → misalign_o pulse, next if_addr_o=0x80000000.
  - without → next if_addr_o=0x800000a0, misalign_o=0.
